line_fill_responder: RTL and testbench
======================================

// Module: line_fill_responder
// PURPOSE
//  Memory-side responder that serves directCache line refills and dirty-line writebacks.
//  Accepts one line request at a time. Line payload moves as a burst of DATA_WIDTH beats,
//  and rdone pulses at completion (the cache's "mod"/rdone input).
//  Backing store is an on-chip array of 2**MEM_LINES_LOG2 lines, used as a
//  simulation/FPGA memory model behind the cache.
// PARAMETERS
//  ADDR_WIDTH      64  request address width
//  DATA_WIDTH      64  beat width; one cache word per beat
//  OFFSET_LENGTH   5   word-offset bits; BEATS = 2**OFFSET_LENGTH beats per line
//  MEM_LINES_LOG2  6   log2 of lines held in the backing store
//  LATENCY         4   access latency in cycles; legal range 1..255
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           asynchronous, active-high reset
//  req_valid    in   1           line request valid
//  req_ready    out  1           responder can accept a request
//  req_addr     in   ADDR_WIDTH  byte-agnostic word address; offset bits are ignored
//  req_write    in   1           1 = writeback (cache->mem), 0 = refill (mem->cache)
//  wdata_valid  in   1           writeback beat valid
//  wdata_ready  out  1           responder accepts writeback beat
//  wdata        in   DATA_WIDTH  writeback beat
//  rdata_valid  out  1           refill beat valid
//  rdata_ready  in   1           cache accepts refill beat
//  rdata        out  DATA_WIDTH  refill beat
//  rdata_last   out  1           marks final refill beat (beat BEATS-1)
//  rdone        out  1           one-cycle pulse: line transfer complete
// BEHAVIOUR
//  Reset:
//   - Reset is asynchronous, active-high. State -> IDLE.
//   - All outputs are 0 except req_ready, which is 1. Counters are cleared.
//   - Storage contents are not reset.
//  Line index: line = req_addr[OFFSET_LENGTH +: MEM_LINES_LOG2].
//   - Upper bits are ignored, so addresses alias modulo the store size.
//   - Address, line index and req_write are latched on acceptance.
//  Handshakes:
//   - A transfer occurs on a rising edge where valid && ready.
//   - rdata and rdata_last are held stable while rdata_valid && !rdata_ready.
//  FSM states: IDLE, RLAT, RBURST, WBURST, WLAT, DONE.
//   - IDLE: req_ready=1. On acceptance, go to RLAT if !req_write, else WBURST.
//   - RLAT: wait LATENCY cycles. The first rdata_valid occurs exactly LATENCY cycles
//     after the acceptance edge.
//   - RBURST: beat counter runs 0..BEATS-1 and drives mem[line][beat].
//     - The counter advances only on an rdata handshake.
//     - After the handshake on beat BEATS-1, go to DONE.
//   - WBURST: wdata_ready=1. Each wdata handshake writes mem[line][beat] and increments
//     the counter. After beat BEATS-1, go to WLAT.
//   - WLAT: wait LATENCY cycles, then go to DONE.
//   - DONE: rdone=1 for exactly one cycle with req_ready=0, then go to IDLE.
//     - A request presented during DONE waits; it is accepted in IDLE on the next cycle.
//     - Minimum request-to-request spacing is therefore 2 cycles after the last beat.
//  Output validity by state:
//   - rdata_valid is 1 only in RBURST; wdata_ready is 1 only in WBURST.
//   - rdata_last = RBURST && (beat == BEATS-1).
//  Widths and wrap:
//   - Beat counter is OFFSET_LENGTH bits and wraps to 0 on leaving a burst.
//   - Latency counter is 8 bits, loaded with LATENCY-1 and decremented to 0.
//  Stalls: wdata_valid low in WBURST, or rdata_ready low in RBURST, holds the beat
//   counter with no timeout.
//  Reset mid-operation:
//   - The burst is aborted asynchronously; outputs immediately take their reset values.
//   - Writeback beats already written stay committed; the partial line is not rolled back.
//   - No rdone is issued for an aborted transfer.
//  Illegal input: req_write and req_addr are ignored outside the acceptance edge.
//   - wdata_valid outside WBURST is ignored and writes nothing.
// TESTING  (OFFSET_LENGTH=2 -> BEATS=4, LATENCY=3, MEM_LINES_LOG2=4)
//  1. Writeback line 5 with beats A0..A3 = 0x11,0x22,0x33,0x44 and wdata_valid held high.
//     -> 4 consecutive wdata handshakes, then 3 WLAT cycles, then rdone=1 for 1 cycle.
//  2. Refill addr=5<<2 with rdata_ready=1. -> The acceptance edge is at cycle 0.
//     rdata_valid is high in cycles 3..6 with 0x11,0x22,0x33,0x44; rdata_last is high
//     only in cycle 6; rdone is high in cycle 7.
//  3. Refill with rdata_ready toggled 1,0,0,1,... -> Each beat is held while stalled.
//     Exactly 4 handshakes occur, in order, with no beat duplicated.
//  4. Refill addr=(21<<2)|3 (line 21 aliases to 5, offset ignored).
//     -> Returns 0x11..0x44 starting at beat 0.
//  5. Assert reset in the cycle after beat 1 of a writeback to line 7, then refill line 7.
//     -> Outputs reset immediately; words 0-1 of line 7 hold the new data, words 2-3
//     are unchanged, and no rdone is issued for the aborted writeback.
//  6. Hold req_valid high through DONE.
//     -> req_ready=0 in DONE; the request is accepted on the next IDLE edge.

Source files
------------

// File: rtl/line_fill_responder.sv
// -----------------------------------------------------------------------------
// line_fill_responder
//
// Memory-side responder for a direct-mapped cache. It serves one line request
// at a time: a refill (memory to cache) or a dirty-line writeback (cache to
// memory). The line moves as a burst of 2**OFFSET_LENGTH beats, and rdone
// pulses for one cycle when the transfer is complete. The backing store is an
// on-chip array of 2**MEM_LINES_LOG2 lines. It serves as a simulation or FPGA
// memory model behind the cache.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   req_valid    in   line request valid
//   req_ready    out  responder can accept a request (IDLE only)
//   req_addr     in   word address; offset bits and bits above the line index
//                     are ignored
//   req_write    in   1 = writeback, 0 = refill
//   wdata_valid  in   writeback beat valid
//   wdata_ready  out  writeback beat accepted (WBURST only)
//   wdata        in   writeback beat
//   rdata_valid  out  refill beat valid (RBURST only)
//   rdata_ready  in   cache accepts refill beat
//   rdata        out  refill beat, held stable while stalled
//   rdata_last   out  final refill beat of the line
//   rdone        out  one-cycle pulse, line transfer complete
//
// All outputs are registered. Each output's next value is decoded from the
// next state, so every output changes on the same edge as the state.
// -----------------------------------------------------------------------------
module line_fill_responder #(
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned OFFSET_LENGTH  = 5,
   parameter int unsigned MEM_LINES_LOG2 = 6,
   parameter int unsigned LATENCY        = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_write,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  rdata_valid,
   input  logic                  rdata_ready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rdata_last,
   output logic                  rdone
);

   localparam int unsigned IdxW  = MEM_LINES_LOG2 + OFFSET_LENGTH;
   localparam int unsigned Depth = 1 << IdxW;
   // Latency counter counts LATENCY cycles: loaded with LATENCY-1, exits at 0.
   localparam logic [7:0] LatInit = 8'(LATENCY - 1);
   localparam logic [OFFSET_LENGTH-1:0] LastBeat = {OFFSET_LENGTH{1'b1}};

   typedef enum logic [2:0] {
      StIdle,
      StRlat,
      StRburst,
      StWburst,
      StWlat,
      StDone
   } state_e;

   // Backing store, one word per beat, indexed by {line, beat}. Not reset.
   logic [DATA_WIDTH-1:0] mem [Depth];

   state_e                    state_q, state_d;
   logic [OFFSET_LENGTH-1:0]  beat_q, beat_d;
   logic [7:0]                lat_q, lat_d;
   logic [MEM_LINES_LOG2-1:0] line_q, line_d;

   logic                  req_ready_q, req_ready_d;
   logic                  wdata_ready_q, wdata_ready_d;
   logic                  rdata_valid_q, rdata_valid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rdata_last_q, rdata_last_d;
   logic                  rdone_q, rdone_d;

   logic            mem_we;
   logic [IdxW-1:0] mem_widx;
   logic [IdxW-1:0] mem_ridx;

   // Address bits outside the line index play no part in addressing.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:IdxW], req_addr[OFFSET_LENGTH-1:0]};

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      lat_d    = lat_q;
      line_d   = line_q;
      mem_we   = 1'b0;
      mem_widx = {line_q, beat_q};

      unique case (state_q)
         StIdle: begin
            beat_d = '0;
            if (req_valid) begin
               line_d = req_addr[OFFSET_LENGTH +: MEM_LINES_LOG2];
               if (req_write) begin
                  state_d = StWburst;
               end else begin
                  state_d = StRlat;
                  lat_d   = LatInit;
               end
            end
         end

         StRlat: begin
            if (lat_q == 8'd0) begin
               state_d = StRburst;
            end else begin
               lat_d = lat_q - 8'd1;
            end
         end

         StRburst: begin
            // The beat advances only on a handshake. This holds rdata while stalled.
            if (rdata_ready) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == LastBeat) begin
                  state_d = StDone;
               end
            end
         end

         StWburst: begin
            if (wdata_valid) begin
               mem_we = 1'b1;
               beat_d = beat_q + 1'b1;
               if (beat_q == LastBeat) begin
                  state_d = StWlat;
                  lat_d   = LatInit;
               end
            end
         end

         StWlat: begin
            if (lat_q == 8'd0) begin
               state_d = StDone;
            end else begin
               lat_d = lat_q - 8'd1;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output decode from the next state. Register these values so that they
   // line up with state_q.
   // ---------------------------------------------------------------------------
   assign mem_ridx = {line_d, beat_d};

   always_comb begin
      req_ready_d   = (state_d == StIdle);
      wdata_ready_d = (state_d == StWburst);
      rdata_valid_d = (state_d == StRburst);
      rdata_last_d  = (state_d == StRburst) && (beat_d == LastBeat);
      rdone_d       = (state_d == StDone);
      rdata_d       = '0;
      // Reads and writes never share an edge. No bypass is needed.
      if (state_d == StRburst) begin
         rdata_d = mem[mem_ridx];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         beat_q        <= '0;
         lat_q         <= '0;
         line_q        <= '0;
         req_ready_q   <= 1'b1;
         wdata_ready_q <= 1'b0;
         rdata_valid_q <= 1'b0;
         rdata_q       <= '0;
         rdata_last_q  <= 1'b0;
         rdone_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         beat_q        <= beat_d;
         lat_q         <= lat_d;
         line_q        <= line_d;
         req_ready_q   <= req_ready_d;
         wdata_ready_q <= wdata_ready_d;
         rdata_valid_q <= rdata_valid_d;
         rdata_q       <= rdata_d;
         rdata_last_q  <= rdata_last_d;
         rdone_q       <= rdone_d;
      end
   end

   // Writeback beats commit as they arrive. A later reset leaves them in place.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_widx] <= wdata;
      end
   end

   assign req_ready   = req_ready_q;
   assign wdata_ready = wdata_ready_q;
   assign rdata_valid = rdata_valid_q;
   assign rdata       = rdata_q;
   assign rdata_last  = rdata_last_q;
   assign rdone       = rdone_q;

endmodule

// File: tb/tb_line_fill_responder.sv
// -----------------------------------------------------------------------------
// tb_line_fill_responder
//
// Bench for line_fill_responder with BEATS=4, LATENCY=3 and 16 lines. A
// transaction-level model tracks the memory contents and the current line
// transfer as timestamps. The timestamps are the acceptance cycle, the first
// valid cycle, the beat count and the rdone cycle. A compare process checks
// every DUT output against the model on each negedge. Directed tests add
// literal expectations on data and cycle offsets.
// -----------------------------------------------------------------------------
module tb_line_fill_responder;

   localparam int unsigned OL    = 2;
   localparam int unsigned ML    = 4;
   localparam int unsigned LAT   = 3;
   localparam int          BEATS = 4;
   localparam int          LINES = 16;

   logic        clk         = 1'b0;
   logic        reset       = 1'b1;
   logic        req_valid   = 1'b0;
   logic        req_write   = 1'b0;
   logic [63:0] req_addr    = '0;
   logic        wdata_valid = 1'b0;
   logic [63:0] wdata       = '0;
   logic        rdata_ready = 1'b0;
   logic        req_ready, wdata_ready, rdata_valid, rdata_last, rdone;
   logic [63:0] rdata;

   line_fill_responder #(
      .ADDR_WIDTH    (64),
      .DATA_WIDTH    (64),
      .OFFSET_LENGTH (OL),
      .MEM_LINES_LOG2(ML),
      .LATENCY       (LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_write  (req_write),
      .wdata_valid(wdata_valid),
      .wdata_ready(wdata_ready),
      .wdata      (wdata),
      .rdata_valid(rdata_valid),
      .rdata_ready(rdata_ready),
      .rdata      (rdata),
      .rdata_last (rdata_last),
      .rdone      (rdone)
   );

   initial forever #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   int          cyc = 0;
   bit          m_busy = 0;
   bit          m_rd = 0;
   int          m_line = 0;
   int          m_first = 0;
   int          m_cnt = 0;
   longint      m_done = -1;
   logic [63:0] m_mem [LINES*BEATS];
   bit          m_known [LINES*BEATS];
   bit          accept;

   function automatic bit exp_rv();
      return m_busy && m_rd && (cyc >= m_first) && (m_cnt < BEATS);
   endfunction

   function automatic bit exp_wr();
      return m_busy && !m_rd && (m_cnt < BEATS);
   endfunction

   function automatic bit exp_done();
      return m_busy && (longint'(cyc) == m_done);
   endfunction

   initial forever begin
      @(posedge clk);
      if (reset) begin
         m_busy = 0;
         m_done = -1;
         cyc++;
      end else begin
         accept = !m_busy && req_valid;
         if (exp_rv() && rdata_ready) begin
            m_cnt++;
            if (m_cnt == BEATS) m_done = cyc + 1;
         end else if (exp_wr() && wdata_valid) begin
            m_mem[m_line*BEATS + m_cnt]   = wdata;
            m_known[m_line*BEATS + m_cnt] = 1'b1;
            m_cnt++;
            if (m_cnt == BEATS) m_done = cyc + 1 + LAT;
         end
         cyc++;
         if (m_busy && longint'(cyc) == m_done + 1) m_busy = 0;
         if (accept) begin
            m_busy  = 1;
            m_rd    = !req_write;
            m_line  = int'((req_addr >> OL) & 64'(LINES - 1));
            m_cnt   = 0;
            m_first = cyc + LAT;
            m_done  = -1;
         end
      end
   end

   // ---------------- compare and observation process ----------------
   logic [63:0] rx_q [$];
   int          whs_q [$];
   int          acc_q [$];
   bit          rv_seen = 0;
   int          first_rv = 0;
   int          last_hs = 0;
   int          rdone_cnt = 0;
   int          rdone_cyc = 0;
   logic        done_ready = 1'b0;
   int          idx;

   initial forever begin
      @(negedge clk);
      if (!reset) begin
         idx = m_line*BEATS + m_cnt;
         check("req_ready", req_ready, !m_busy);
         check("rdata_valid", rdata_valid, exp_rv());
         check("rdata_last", rdata_last, exp_rv() && (m_cnt == BEATS-1));
         check("wdata_ready", wdata_ready, exp_wr());
         check("rdone", rdone, exp_done());
         if (exp_rv() && m_known[idx]) check("rdata", rdata, m_mem[idx]);

         if (rdata_valid && !rv_seen) begin
            rv_seen  = 1;
            first_rv = cyc;
         end
         if (rdata_valid && rdata_ready) begin
            rx_q.push_back(rdata);
            if (rdata_last) last_hs = cyc;
         end
         if (wdata_valid && wdata_ready) whs_q.push_back(cyc);
         if (req_valid && req_ready) acc_q.push_back(cyc + 1);
         if (rdone) begin
            rdone_cnt++;
            rdone_cyc  = cyc;
            done_ready = req_ready;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   // Present a request, wait for acceptance, return the cycle after the edge.
   task automatic issue(input logic [63:0] addr, input logic wr, output int e);
      bit ok = 0;
      req_valid = 1'b1;
      req_addr  = addr;
      req_write = wr;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("accept_timeout", req_ready, 1);
      @(posedge clk);
      #1;
      e         = cyc;
      req_valid = 1'b0;
      req_write = ~wr;   // must be ignored after acceptance
      req_addr  = {$urandom, $urandom};
   endtask

   task automatic writeback(input logic [63:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3, input int nb,
                            output int e);
      logic [63:0] d [4];
      bit ok;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      whs_q.delete();
      issue(addr, 1'b1, e);
      for (int i = 0; i < nb; i++) begin
         wdata_valid = 1'b1;
         wdata       = d[i];
         ok          = 0;
         for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (wdata_ready) begin
               ok = 1;
               break;
            end
         end
         if (!ok) check("wdata_timeout", wdata_ready, 1);
         @(posedge clk);
         #1;
      end
      wdata_valid = 1'b0;
      wdata       = {$urandom, $urandom};
   endtask

   task automatic wait_rdone(input int base, output int c);
      bit ok = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         #1;
         if (rdone_cnt > base) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("rdone_timeout", rdone_cnt, base + 1);
      c = rdone_cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic refill(input logic [63:0] addr, input bit stall, output int e, output int c);
      int base = rdone_cnt;
      bit ok   = 0;
      rx_q.delete();
      rv_seen = 0;
      issue(addr, 1'b0, e);
      for (int k = 0; k < 100; k++) begin
         rdata_ready = stall ? pat[k % 4] : 1'b1;
         @(negedge clk);
         #1;
         if (rdone_cnt > base) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check("refill_rdone_timeout", rdone_cnt, base + 1);
      c           = rdone_cyc;
      rdata_ready = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_line(input string name, input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3);
      logic [63:0] d [4];
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      check({name, "_count"}, rx_q.size(), BEATS);
      for (int i = 0; i < BEATS; i++) begin
         if (i < rx_q.size()) check($sformatf("%s_beat%0d", name, i), rx_q[i], d[i]);
      end
   endtask

   // ---------------- directed tests ----------------
   int e, c, base, e1;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_rdata_valid", rdata_valid, 0);
      check("rst_wdata_ready", wdata_ready, 0);
      check("rst_rdone", rdone, 0);
      check("rst_rdata_last", rdata_last, 0);
      check("rst_rdata", rdata, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 1: writeback line 5, beats back to back
      base = rdone_cnt;
      writeback(64'd20, 64'h11, 64'h22, 64'h33, 64'h44, 4, e);
      wait_rdone(base, c);
      check("t1_whs_count", whs_q.size(), 4);
      if (whs_q.size() == 4) begin
         check("t1_whs_first", whs_q[0] - e, 0);
         check("t1_whs_span", whs_q[3] - whs_q[0], 3);
      end
      check("t1_rdone_ofs", c - e, 7);

      // 2: refill line 5, no stall
      refill(64'd20, 1'b0, e, c);
      check("t2_first_valid_ofs", first_rv - e, 3);
      check("t2_last_ofs", last_hs - e, 6);
      check("t2_rdone_ofs", c - e, 7);
      check_line("t2", 64'h11, 64'h22, 64'h33, 64'h44);

      // 3: refill with rdata_ready stalls
      refill(64'd20, 1'b1, e, c);
      check_line("t3", 64'h11, 64'h22, 64'h33, 64'h44);

      // Stray wdata_valid while idle must not write
      wdata_valid = 1'b1;
      wdata       = 64'hdead_beef;
      repeat (3) @(posedge clk);
      #1;
      wdata_valid = 1'b0;

      // 4: aliased address with nonzero offset
      refill((64'd21 << 2) | 64'd3, 1'b0, e, c);
      check_line("t4", 64'h11, 64'h22, 64'h33, 64'h44);

      // 5: reset in the middle of a writeback to line 7
      base = rdone_cnt;
      writeback(64'd28, 64'ha0, 64'ha1, 64'ha2, 64'ha3, 4, e);
      wait_rdone(base, c);
      base = rdone_cnt;
      writeback(64'd28, 64'hb0, 64'hb1, 64'hb2, 64'hb3, 2, e);
      reset = 1'b1;
      #1;
      check("t5_req_ready", req_ready, 1);
      check("t5_wdata_ready", wdata_ready, 0);
      check("t5_rdone", rdone, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("t5_no_rdone", rdone_cnt, base);
      refill(64'd28, 1'b0, e, c);
      check_line("t5", 64'hb0, 64'hb1, 64'ha2, 64'ha3);

      // 6: req_valid held through DONE
      acc_q.delete();
      base      = rdone_cnt;
      req_valid = 1'b1;
      req_addr  = 64'd20;
      req_write = 1'b0;
      rdata_ready = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         #1;
         if (acc_q.size() >= 2) break;
      end
      check("t6_accepts", acc_q.size(), 2);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (acc_q.size() >= 2) begin
         e1 = acc_q[0];
         check("t6_spacing", acc_q[1] - e1, 9);
      end
      check("t6_ready_in_done", done_ready, 0);
      wait_rdone(base + 1, c);
      check("t6_rdone_ofs", c - acc_q[acc_q.size()-1], 7);
      rdata_ready = 1'b0;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
